ps2_host_fifo: RTL

//  Parametrised PS/2 host transceiver; next generation of the single-byte PS/2 controller.

---
 rtl/ps2_host_fifo.sv | 241 ++++++++++++++++++++++++
 1 files changed

// File: rtl/ps2_host_fifo.sv
// ps2_host_fifo: PS/2 host transceiver with RX/TX FIFOs, odd parity, frame watchdogs and sticky errors.
// Build with PS2_AUTO_INIT_EN defined to send INIT_CMD once after reset, ahead of queued commands.
module ps2_host_fifo #(
    parameter int         CLK_HZ   = 50_000_000,
    parameter int         RX_DEPTH = 16,
    parameter int         TX_DEPTH = 4,
    parameter logic [7:0] INIT_CMD = 8'hF4
) (
    input  logic                      CLOCK_50,
    input  logic                      reset,
    inout  wire                       PS2_CLK,
    inout  wire                       PS2_DAT,
    input  logic [7:0]                tx_data,
    input  logic                      tx_valid,
    output logic                      tx_ready,
    output logic [7:0]                rx_data,
    output logic                      rx_valid,
    input  logic                      rx_ready,
    output logic [$clog2(RX_DEPTH):0] rx_level,
    output logic                      err_parity,
    output logic                      err_timeout,
    output logic                      err_overflow,
    output logic                      tx_acked,
    input  logic                      err_clear
);
    localparam int GAP_CYC  = CLK_HZ / 20000;
    localparam int INH_CYC  = CLK_HZ / 10000;
    localparam int REQ_CYC  = CLK_HZ / 66;
    localparam int EDGE_CYC = CLK_HZ / 500;
    localparam int TW       = $clog2(REQ_CYC + 1);
    localparam int GW       = $clog2(GAP_CYC + 1);
    localparam int RAW      = $clog2(RX_DEPTH);
    localparam int TAW      = $clog2(TX_DEPTH);
`ifdef PS2_AUTO_INIT_EN
    localparam logic INIT_AT_RESET = 1'b1;
`else
    localparam logic INIT_AT_RESET = 1'b0;
`endif

    typedef enum logic [2:0] {S_IDLE, S_RX, S_TX_INH, S_TX_REQ, S_TX_SHIFT, S_TX_ACK} state_t;

    state_t          state_reg, state_next;
    logic [2:0]      clk_sync_reg;
    logic [1:0]      dat_sync_reg;
    logic [TW-1:0]   tmr_reg, tmr_next;
    logic [GW-1:0]   gap_reg, gap_next;
    logic [3:0]      bit_cnt_reg, bit_cnt_next;
    logic [8:0]      shift_reg, shift_next;
    logic            dat_low_reg, dat_low_next;
    logic            init_pending_reg, init_pending_next;
    logic            run_reg;
    logic            err_parity_reg, err_timeout_reg, err_overflow_reg, tx_acked_reg;
    logic            rx_push, tx_pop, perr_set, tout_set, ack_set;

    logic [7:0]      rx_mem [RX_DEPTH];
    logic [RAW-1:0]  rx_wr_ptr_reg, rx_rd_ptr_reg;
    logic [RAW:0]    rx_cnt_reg;
    logic [7:0]      tx_mem [TX_DEPTH];
    logic [TAW-1:0]  tx_wr_ptr_reg, tx_rd_ptr_reg;
    logic [TAW:0]    tx_cnt_reg;

    logic clk_s, dat_s, clk_fall, clk_edge, gap_sat;
    logic rx_full, rx_pop, rx_wr_en, ovf_set, tx_full, tx_empty, tx_wr_en;

    assign clk_s    = clk_sync_reg[1];
    assign dat_s    = dat_sync_reg[1];
    assign clk_fall = clk_sync_reg[2] & ~clk_s;
    assign clk_edge = clk_sync_reg[2] ^ clk_s;
    assign gap_sat  = (gap_reg == GW'(GAP_CYC));

    assign rx_valid = (rx_cnt_reg != '0);
    assign rx_full  = (rx_cnt_reg == (RAW+1)'(RX_DEPTH));
    assign rx_pop   = rx_valid & rx_ready;
    assign rx_wr_en = rx_push & (~rx_full | rx_pop);
    assign ovf_set  = rx_push & rx_full & ~rx_pop;
    assign tx_full  = (tx_cnt_reg == (TAW+1)'(TX_DEPTH));
    assign tx_empty = (tx_cnt_reg == '0);
    assign tx_ready = run_reg & ~tx_full & ~init_pending_reg;
    assign tx_wr_en = tx_valid & tx_ready;

    assign rx_data      = rx_valid ? rx_mem[rx_rd_ptr_reg] : 8'h00;
    assign rx_level     = rx_cnt_reg;
    assign err_parity   = err_parity_reg;
    assign err_timeout  = err_timeout_reg;
    assign err_overflow = err_overflow_reg;
    assign tx_acked     = tx_acked_reg;

    // Open-drain pins: only ever pulled low, otherwise released to the bus pull-ups.
    assign PS2_CLK = (state_reg == S_TX_INH) ? 1'b0 : 1'bz;
    assign PS2_DAT = dat_low_reg ? 1'b0 : 1'bz;

    always_comb begin
        state_next        = state_reg;
        tmr_next          = tmr_reg + 1'b1;
        bit_cnt_next      = bit_cnt_reg;
        shift_next        = shift_reg;
        dat_low_next      = dat_low_reg;
        init_pending_next = init_pending_reg;
        gap_next          = '0;
        rx_push           = 1'b0;
        tx_pop            = 1'b0;
        perr_set          = 1'b0;
        tout_set          = 1'b0;
        ack_set           = 1'b0;
        if (state_reg == S_IDLE && clk_s && dat_s)
            gap_next = gap_sat ? gap_reg : gap_reg + 1'b1;
        case (state_reg)
            S_IDLE: begin
                tmr_next     = '0;
                bit_cnt_next = '0;
                dat_low_next = 1'b0;
                if (clk_fall && !dat_s) begin
                    state_next = S_RX;
                end else if (gap_sat && (init_pending_reg || !tx_empty)) begin
                    state_next = S_TX_INH;
                    tx_pop     = ~init_pending_reg;
                    shift_next = {1'b0, init_pending_reg ? INIT_CMD : tx_mem[tx_rd_ptr_reg]};
                end
            end
            S_RX: begin
                // Nine shifts leave data in [7:0] and parity in [8]; the tenth fall is the stop bit.
                if (clk_fall) begin
                    tmr_next = '0;
                    if (bit_cnt_reg == 4'd9) begin
                        state_next = S_IDLE;
                        if ((^shift_reg) && dat_s) rx_push = 1'b1;
                        else                        perr_set = 1'b1;
                    end else begin
                        shift_next   = {dat_s, shift_reg[8:1]};
                        bit_cnt_next = bit_cnt_reg + 1'b1;
                    end
                end else if (clk_edge) begin
                    tmr_next = '0;
                end else if (tmr_reg == TW'(EDGE_CYC - 1)) begin
                    tout_set   = 1'b1;
                    state_next = S_IDLE;
                end
            end
            S_TX_INH: begin
                if (tmr_reg == TW'(INH_CYC - 1)) begin
                    state_next   = S_TX_REQ;
                    tmr_next     = '0;
                    dat_low_next = 1'b1;
                end
            end
            S_TX_REQ: state_next = S_TX_SHIFT;
            S_TX_SHIFT: begin
                // Until the first device fall, the rising edge of our own released clock is ignored.
                if (clk_fall) begin
                    tmr_next     = '0;
                    bit_cnt_next = bit_cnt_reg + 1'b1;
                    if (bit_cnt_reg < 4'd8) begin
                        dat_low_next = ~shift_reg[bit_cnt_reg[2:0]];
                    end else if (bit_cnt_reg == 4'd8) begin
                        dat_low_next = ^shift_reg[7:0];
                    end else begin
                        dat_low_next = 1'b0;
                        state_next   = S_TX_ACK;
                    end
                end else if (clk_edge && bit_cnt_reg != 4'd0) begin
                    tmr_next = '0;
                end else if ((bit_cnt_reg == 4'd0) ? (tmr_reg == TW'(REQ_CYC - 1))
                                                   : (tmr_reg == TW'(EDGE_CYC - 1))) begin
                    tout_set          = 1'b1;
                    dat_low_next      = 1'b0;
                    init_pending_next = 1'b0;
                    state_next        = S_IDLE;
                end
            end
            S_TX_ACK: begin
                if (clk_fall) begin
                    state_next        = S_IDLE;
                    init_pending_next = 1'b0;
                    if (!dat_s) ack_set  = ~init_pending_reg;
                    else        tout_set = 1'b1;
                end else if (clk_edge) begin
                    tmr_next = '0;
                end else if (tmr_reg == TW'(EDGE_CYC - 1)) begin
                    tout_set          = 1'b1;
                    init_pending_next = 1'b0;
                    state_next        = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state_reg        <= S_IDLE;
            clk_sync_reg     <= '1;
            dat_sync_reg     <= '1;
            tmr_reg          <= '0;
            gap_reg          <= '0;
            bit_cnt_reg      <= '0;
            shift_reg        <= '0;
            dat_low_reg      <= 1'b0;
            init_pending_reg <= INIT_AT_RESET;
            run_reg          <= 1'b0;
            err_parity_reg   <= 1'b0;
            err_timeout_reg  <= 1'b0;
            err_overflow_reg <= 1'b0;
            tx_acked_reg     <= 1'b0;
            rx_wr_ptr_reg    <= '0;
            rx_rd_ptr_reg    <= '0;
            rx_cnt_reg       <= '0;
            tx_wr_ptr_reg    <= '0;
            tx_rd_ptr_reg    <= '0;
            tx_cnt_reg       <= '0;
        end else begin
            state_reg        <= state_next;
            clk_sync_reg     <= {clk_sync_reg[1:0], PS2_CLK};
            dat_sync_reg     <= {dat_sync_reg[0], PS2_DAT};
            tmr_reg          <= tmr_next;
            gap_reg          <= gap_next;
            bit_cnt_reg      <= bit_cnt_next;
            shift_reg        <= shift_next;
            dat_low_reg      <= dat_low_next;
            init_pending_reg <= init_pending_next;
            run_reg          <= 1'b1;
            // A set in the same cycle as err_clear takes precedence.
            err_parity_reg   <= perr_set | (err_parity_reg & ~err_clear);
            err_timeout_reg  <= tout_set | (err_timeout_reg & ~err_clear);
            err_overflow_reg <= ovf_set | (err_overflow_reg & ~err_clear);
            tx_acked_reg     <= ack_set;
            if (rx_wr_en) rx_wr_ptr_reg <= rx_wr_ptr_reg + 1'b1;
            if (rx_pop)   rx_rd_ptr_reg <= rx_rd_ptr_reg + 1'b1;
            if (rx_wr_en && !rx_pop)      rx_cnt_reg <= rx_cnt_reg + 1'b1;
            else if (!rx_wr_en && rx_pop) rx_cnt_reg <= rx_cnt_reg - 1'b1;
            if (tx_wr_en) tx_wr_ptr_reg <= tx_wr_ptr_reg + 1'b1;
            if (tx_pop)   tx_rd_ptr_reg <= tx_rd_ptr_reg + 1'b1;
            if (tx_wr_en && !tx_pop)      tx_cnt_reg <= tx_cnt_reg + 1'b1;
            else if (!tx_wr_en && tx_pop) tx_cnt_reg <= tx_cnt_reg - 1'b1;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (rx_wr_en) rx_mem[rx_wr_ptr_reg] <= shift_reg[7:0];
        if (tx_wr_en) tx_mem[tx_wr_ptr_reg] <= tx_data;
    end
endmodule
